// File: rtl/fetch_if.sv
// Fetch stage bus: ROM address/data, pipeline control in, fetched word out.
interface fetch_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 5
);
    logic                 stall;
    logic                 flush;
    logic                 branch_taken;
    logic [BITS_ADDR-1:0] branch_target;
    logic [BITS_ADDR-1:0] PC;
    logic [BITS_DATA-1:0] Instr;
    logic [BITS_DATA-1:0] if_instr;
    logic [BITS_ADDR-1:0] if_pc;
    logic                 if_valid;
    logic                 halted;

    modport master (
        input  stall, flush, branch_taken, branch_target, Instr,
        output PC, if_instr, if_pc, if_valid, halted
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, Instr,
        input  PC, if_instr, if_pc, if_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-clock fetch register, BOOT/RUN/HALT FSM.
// Define FETCH_HALT_EN to stop fetching after an all-ones instruction is captured.
module fetch_unit #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]           state;
    logic [BITS_ADDR-1:0] pc;
    logic [BITS_DATA-1:0] if_instr;
    logic [BITS_ADDR-1:0] if_pc;
    logic                 if_valid;
    logic                 halt_word;

`ifdef FETCH_HALT_EN
    assign halt_word = (bus.Instr == {BITS_DATA{1'b1}});
`else
    assign halt_word = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= '0;
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (bus.branch_taken) begin
                        pc       <= bus.branch_target;
                        if_valid <= 1'b0;
                    end else if (bus.flush) begin
                        if_valid <= 1'b0;
                        if (!bus.stall) pc <= pc + 1'b1;
                    end else if (!bus.stall) begin
                        // Capture completes even for the halt word; FSM stops afterwards.
                        if_instr <= bus.Instr;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + 1'b1;
                        if (halt_word) state <= HALT;
                    end
                end
                HALT: if_valid <= 1'b0;
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.PC       = pc;
    assign bus.if_instr = if_instr;
    assign bus.if_pc    = if_pc;
    assign bus.if_valid = if_valid;
`ifdef FETCH_HALT_EN
    assign bus.halted   = (state == HALT);
`else
    assign bus.halted   = 1'b0;
`endif
endmodule
